seq_distance_calculator: RTL and testbench
==========================================

# seq_distance_calculator

Sequential, handshaked successor of the combinational redundant-weight distance calculator: computes the input-stream reuse distance `dr = ((OW-FW)*dv + d) / S` for one redundant weight pair per transaction. Shared iterative restoring dividers replace the combinational dividers, and all widths are parameters. The block sits between the redundancy detector (producer of index pairs) and the reuse scheduler (consumer of `dr`). It flags stride exceptions, distance overflow and illegal operands.

## Interface
- `WORD_WIDTH`, 8: width of indices and shape operands (W).
- `DIST_WIDTH`, 7: width of `dr` output; must be ≤ 2·W.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block can accept a request.
- `idx1` input W: smaller index of the redundant pair.
- `idx2` input W: larger index of the redundant pair.
- `ow` input W: output width OW.
- `fw` input W: filter width FW.
- `st` input W: stride S.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `dr` output DIST_WIDTH: distance, low DIST_WIDTH bits of the quotient.
- `dist_valid` output 1: `dr` is usable (no overflow, no stride remainder, no error).
- `err` output 1: illegal operands (`fw==0`, `st==0`, `idx2<idx1`, or `ow<fw`).

## Operation
- States: IDLE, DIV_IDX, MUL, DIV_ST, DONE.
- `in_ready = (state==IDLE)`. Accept on `in_valid & in_ready`; register all five operands and go to DIV_IDX.
- DIV_IDX: two parallel W-bit restoring dividers compute `q1=idx1/fw` and `q2=idx2/fw`, one quotient bit per cycle, for W cycles.
- MUL: one cycle. Registers:
  - `d = idx2-idx1` (W bits)
  - `dv = q2-q1` (W bits)
  - `wd = ow-fw` (W bits)
  - `nst = wd*dv + d`, computed at 2W+1 bits; bit 2W is the carry into the overflow flag.
- DIV_ST: 2W-bit restoring divider computes `nst[2W-1:0] / st`, giving quotient `qr` and remainder `rm`; one bit per cycle, for 2W cycles.
- DONE: `out_valid=1`; outputs held stable until `out_ready`; then go to IDLE.
- Output assignments:
  - `dr = qr[DIST_WIDTH-1:0]`.
  - `dist_valid = ~err & ~carry & ~|qr[2W-1:DIST_WIDTH] & ~|rm`.
- `err` is evaluated from the registered operands. An erroring transaction still runs the full schedule (fixed latency). With a zero divisor, divider contents are don't-care, but `err=1` and `dist_valid=0`.
- Unsigned arithmetic throughout; subtractions wrap modulo 2^W. Wrapped values matter only when `err=1`.
- `in_valid` held during busy states is ignored, not queued. Operand changes after acceptance have no effect.

## Timing
- Reset (async assert, sync release): state IDLE, `in_ready=1`, `out_valid=0`, `dr=0`, `dist_valid=0`, `err=0`, all datapath registers 0.
- Latency is fixed: `out_valid` rises exactly 3W+1 rising edges after the acceptance edge (25 for W=8), independent of operand values.
- Result handshake completes on the edge with `out_valid & out_ready`. `in_ready` is 1 from the next cycle; no acceptance is possible in the same cycle as the result handshake.
- Back-to-back throughput: one transaction per 3W+3 cycles when `out_ready` is tied high.
- `out_ready` may be high before `out_valid`; it has no effect outside DONE.
- `reset_n` low mid-transaction: the transaction is aborted immediately; no output is produced for it after release.

## Test plan
- W=8, DIST_WIDTH=7. Input idx1=1, idx2=10, ow=5, fw=3, st=1, `out_ready` high → after 25 edges: `dr=15`, `dist_valid=1`, `err=0`, `out_valid` high one cycle, `in_ready` high the next cycle.
- Same operands with st=2 → `dr=7`, `dist_valid=0` (remainder 1), `err=0`.
- idx1=0, idx2=200, ow=200, fw=3, st=1 → nst=13202; `dr=18`, `dist_valid=0` (overflow), `err=0`.
- Illegal operands → each gives `err=1`, `dist_valid=0`, and output still at 25 edges:
  - fw=0
  - st=0
  - idx1=10, idx2=1
  - ow=2, fw=3
- Backpressure: hold `out_ready` low for 10 cycles after `out_valid` → `dr`, `dist_valid`, `err` stable; `in_ready=0`; `in_valid` pulses ignored. Then release → next request accepted one cycle after the result handshake.
- Assert `reset_n` low at cycle 12 of a transaction → all outputs at reset values asynchronously. A new request after release completes with a correct result and fixed 25-edge latency.

Source files
------------

// File: rtl/seq_distance_calculator.sv
// -----------------------------------------------------------------------------
// seq_distance_calculator
//
// Sequential reuse-distance engine for one redundant weight pair per request:
//   dr = ((OW-FW)*dv + d) / S,  d = idx2-idx1,  dv = idx2/FW - idx1/FW
// Two W-bit restoring dividers run in parallel for the index quotients. One
// multiply cycle follows. Then a 2W-bit restoring divider divides by the stride.
// Latency is fixed at 3W+1 edges from acceptance to out_valid.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   in_valid / in_ready     request handshake (ready only in IDLE)
//   idx1, idx2, ow, fw, st  operands, captured on acceptance
//   out_valid / out_ready   result handshake (held in DONE until out_ready)
//   dr                      low DIST_WIDTH bits of the stride quotient
//   dist_valid              dr usable: no error, no overflow, no remainder
//   err                     illegal operands (fw==0, st==0, idx2<idx1, ow<fw)
// -----------------------------------------------------------------------------

// One restoring-division step. The dividend shifts out of quo MSB-first, and the
// quotient bits shift in at the LSB. The remainder stays below the divisor,
// so D bits hold it.
module seq_div_step #(
    parameter int N = 8,
    parameter int D = 8
) (
    input  logic [D-1:0] rem,
    input  logic [N-1:0] quo,
    input  logic [D-1:0] divisor,
    output logic [D-1:0] rem_nxt,
    output logic [N-1:0] quo_nxt
);
    logic [D:0] shifted;
    logic [D:0] diff;
    logic       ge;

    always_comb begin
        shifted = {rem, quo[N-1]};
        diff    = shifted - {1'b0, divisor};
        ge      = (shifted >= {1'b0, divisor});
        // A zero divisor can overflow rem. The caller flags err and ignores the result.
        rem_nxt = ge ? diff[D-1:0] : shifted[D-1:0];
        quo_nxt = {quo[N-2:0], ge};
    end
endmodule

module seq_distance_calculator #(
    parameter int WORD_WIDTH = 8,
    parameter int DIST_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] idx1,
    input  logic [WORD_WIDTH-1:0] idx2,
    input  logic [WORD_WIDTH-1:0] ow,
    input  logic [WORD_WIDTH-1:0] fw,
    input  logic [WORD_WIDTH-1:0] st,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIST_WIDTH-1:0] dr,
    output logic                  dist_valid,
    output logic                  err
);
    localparam int W  = WORD_WIDTH;
    localparam int W2 = 2 * WORD_WIDTH;
    localparam int CW = $clog2(W2 + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DIV_IDX = 3'd1;
    localparam logic [2:0] S_MUL     = 3'd2;
    localparam logic [2:0] S_DIV_ST  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]          state;
    logic [CW-1:0]       cnt;

    // Captured operands. Index 0 holds idx1 and index 1 holds idx2.
    logic [1:0][W-1:0]   op_idx;
    logic [W-1:0]        op_ow;
    logic [W-1:0]        op_fw;
    logic [W-1:0]        op_st;

    // Index dividers. After W steps, idx_quo holds q1 and q2.
    logic [1:0][W-1:0]   idx_rem, idx_rem_nxt;
    logic [1:0][W-1:0]   idx_quo, idx_quo_nxt;

    // Stride divider. The dividend is the low 2W bits of nst.
    logic [W-1:0]        st_rem, st_rem_nxt;
    logic [W2-1:0]       st_quo, st_quo_nxt;
    logic                carry_r;

    logic [DIST_WIDTH-1:0] dr_r;
    logic                  dist_valid_r;
    logic                  err_r;

    // MUL-cycle terms. The result lands directly in the stride divider.
    logic [W-1:0]        d_c, dv_c, wd_c;
    logic [W2-1:0]       prod_c;
    logic [W2:0]         nst_c;
    logic                err_c;
    logic                dv_ok_c;

    for (genvar g = 0; g < 2; g++) begin : g_idx_div
        seq_div_step #(.N(W), .D(W)) u_idx_div (
            .rem     (idx_rem[g]),
            .quo     (idx_quo[g]),
            .divisor (op_fw),
            .rem_nxt (idx_rem_nxt[g]),
            .quo_nxt (idx_quo_nxt[g])
        );
    end

    seq_div_step #(.N(W2), .D(W)) u_st_div (
        .rem     (st_rem),
        .quo     (st_quo),
        .divisor (op_st),
        .rem_nxt (st_rem_nxt),
        .quo_nxt (st_quo_nxt)
    );

    always_comb begin
        d_c    = op_idx[1] - op_idx[0];
        dv_c   = idx_quo[1] - idx_quo[0];
        wd_c   = op_ow - op_fw;
        prod_c = W2'(wd_c) * W2'(dv_c);
        nst_c  = {1'b0, prod_c} + (W2+1)'(d_c);
        err_c  = (op_fw == '0) | (op_st == '0) | (op_idx[1] < op_idx[0]) | (op_ow < op_fw);
        // This is judged on the final divider step, so it is ready when DONE is entered.
        dv_ok_c = ~err_c & ~carry_r & ((st_quo_nxt >> DIST_WIDTH) == '0) & (st_rem_nxt == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            op_idx       <= '0;
            op_ow        <= '0;
            op_fw        <= '0;
            op_st        <= '0;
            idx_rem      <= '0;
            idx_quo      <= '0;
            st_rem       <= '0;
            st_quo       <= '0;
            carry_r      <= 1'b0;
            dr_r         <= '0;
            dist_valid_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_idx  <= {idx2, idx1};
                        op_ow   <= ow;
                        op_fw   <= fw;
                        op_st   <= st;
                        idx_quo <= {idx2, idx1};
                        idx_rem <= '0;
                        cnt     <= '0;
                        state   <= S_DIV_IDX;
                    end
                end
                S_DIV_IDX: begin
                    idx_rem <= idx_rem_nxt;
                    idx_quo <= idx_quo_nxt;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) state <= S_MUL;
                end
                S_MUL: begin
                    st_quo  <= nst_c[W2-1:0];
                    st_rem  <= '0;
                    carry_r <= nst_c[W2];
                    cnt     <= '0;
                    state   <= S_DIV_ST;
                end
                S_DIV_ST: begin
                    st_rem <= st_rem_nxt;
                    st_quo <= st_quo_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(W2 - 1)) begin
                        dr_r         <= st_quo_nxt[DIST_WIDTH-1:0];
                        dist_valid_r <= dv_ok_c;
                        err_r        <= err_c;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state == S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign dr         = dr_r;
    assign dist_valid = dist_valid_r;
    assign err        = err_r;
endmodule

// File: tb/tb_seq_distance_calculator.sv
module tb_seq_distance_calculator;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] idx1, idx2, ow, fw, st;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] dr;
    logic       dist_valid;
    logic       err;

    int n_chk  = 0;
    int n_pass = 0;

    seq_distance_calculator #(.WORD_WIDTH(8), .DIST_WIDTH(7)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .idx1       (idx1),
        .idx2       (idx2),
        .ow         (ow),
        .fw         (fw),
        .st         (st),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dr         (dr),
        .dist_valid (dist_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model built from the arithmetic definition at W=8.
    task automatic model(input int i1, input int i2, input int o, input int f, input int s,
                         output int edr, output bit edv, output bit eerr);
        int d, dv, wd, nst, qr, rm;
        eerr = (f == 0) || (s == 0) || (i2 < i1) || (o < f);
        edr  = 0;
        edv  = 1'b0;
        if (f != 0 && s != 0) begin
            d   = (i2 - i1) & 255;
            dv  = ((i2 / f) - (i1 / f)) & 255;
            wd  = (o - f) & 255;
            nst = wd * dv + d;
            qr  = (nst & 65535) / s;
            rm  = (nst & 65535) % s;
            edr = qr & 127;
            edv = !eerr && (nst < 65536) && (qr < 128) && (rm == 0);
        end
    endtask

    task automatic do_txn(input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] o,
                          input logic [7:0] f, input logic [7:0] s, input int hold);
        int edr, lat, w;
        bit edv, eerr;
        model(int'(i1), int'(i2), int'(o), int'(f), int'(s), edr, edv, eerr);
        w = 0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        idx1 = i1; idx2 = i2; ow = o; fw = f; st = s;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        // Operand changes after acceptance must not matter.
        in_valid = 1'b0;
        idx1 = 8'($urandom); idx2 = 8'($urandom); ow = 8'($urandom);
        fw = 8'($urandom); st = 8'($urandom);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 100);
        chk("latency", 32'(lat), 32'd25);
        chk("err", 32'(err), 32'(eerr));
        chk("dist_valid", 32'(dist_valid), 32'(edv));
        if (f != 0 && s != 0) chk("dr", 32'(dr), 32'(edr));
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_dr", 32'(dr), 32'(edr));
            chk("hold_dist_valid", 32'(dist_valid), 32'(edv));
            chk("hold_err", 32'(err), 32'(eerr));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] r1, r2, ro, rf, rs;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idx1 = '0; idx2 = '0; ow = '0; fw = '0; st = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dr", 32'(dr), 32'd0);
        chk("rst_dist_valid", 32'(dist_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_txn(8'd1, 8'd10, 8'd5, 8'd3, 8'd1, 0);     // dr=15 valid
        do_txn(8'd1, 8'd10, 8'd5, 8'd3, 8'd2, 0);     // remainder
        do_txn(8'd0, 8'd200, 8'd200, 8'd3, 8'd1, 0);  // overflow, dr=18
        do_txn(8'd1, 8'd10, 8'd5, 8'd0, 8'd1, 0);     // fw=0
        do_txn(8'd1, 8'd10, 8'd5, 8'd3, 8'd0, 0);     // st=0
        do_txn(8'd10, 8'd1, 8'd5, 8'd3, 8'd1, 0);     // idx2<idx1
        do_txn(8'd1, 8'd10, 8'd2, 8'd3, 8'd1, 0);     // ow<fw
        do_txn(8'd1, 8'd10, 8'd5, 8'd3, 8'd1, 10);    // backpressure
        do_txn(8'd4, 8'd9, 8'd7, 8'd2, 8'd3, 0);      // accepted right after handshake

        // Reset at cycle 12 of a transaction.
        in_valid = 1'b1; idx1 = 8'd1; idx2 = 8'd10; ow = 8'd5; fw = 8'd3; st = 8'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_dr", 32'(dr), 32'd0);
        chk("abort_dist_valid", 32'(dist_valid), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (k == 29) chk("abort_no_output", 32'(out_valid), 32'd0);
        end
        do_txn(8'd1, 8'd10, 8'd5, 8'd3, 8'd1, 0);

        // Randomized transactions. Most are legal and biased toward small strides.
        for (int n = 0; n < 24; n++) begin
            if (n % 6 == 5) begin
                r1 = 8'($urandom); r2 = 8'($urandom); ro = 8'($urandom);
                rf = 8'($urandom_range(0, 7)); rs = 8'($urandom_range(0, 4));
            end else begin
                r1 = 8'($urandom_range(0, 200));
                r2 = 8'(int'(r1) + int'($urandom_range(0, 255 - int'(r1))));
                rf = 8'($urandom_range(1, 16));
                ro = 8'($urandom_range(int'(rf), 255));
                rs = 8'($urandom_range(1, 5));
            end
            do_txn(r1, r2, ro, rf, rs, (n % 8 == 3) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
